// File: rtl/gcd_accel.sv
// rtl/gcd_accel.sv - memory-mapped GCD accelerator with job FIFO and multi-cycle engine
// Define GCD_ACCEL_BINARY_EN for the Stein binary engine; default is repeated subtraction.
module gcd_accel #(
    parameter int          WIDTH      = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASE_ADDR  = 16'h00F8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic [31:0] gpio_out,
    output logic        irq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0] ADDR_A1   = BASE_ADDR;
    localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0004;
    localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0008;
    localparam logic [15:0] ADDR_S    = BASE_ADDR + 16'h000C;
    localparam logic [15:0] ADDR_JOBS = BASE_ADDR + 16'h0010;
    localparam logic [15:0] ADDR_ID   = BASE_ADDR + 16'h0014;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     a1_q, a1_d, a2_q, a2_d, w_q, w_d;
    logic [31:0]          jobs_q, jobs_d, rdata_q, rdata_d;
    logic                 ovf_q, ovf_d, done_q, done_d;
    logic [2*WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [2*WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
`ifdef GCD_ACCEL_BINARY_EN
    localparam int KW = $clog2(WIDTH) + 1;
    logic [KW-1:0]        k_q, k_d;
`endif

    logic wr_a1, wr_a2, wr_s, rd_w, fifo_full, fifo_empty, soft_clr, pop, accept, complete;
    logic [WIDTH-1:0] result;
    logic [31:0] status, rmux;

    always_comb begin
        wr_a1      = swr && (saddress == ADDR_A1);
        wr_a2      = swr && (saddress == ADDR_A2);
        wr_s       = swr && (saddress == ADDR_S);
        rd_w       = srd && (saddress == ADDR_W);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        soft_clr   = wr_s && sdata_in[31];
        pop        = (state_q == S_IDLE) && !fifo_empty && !soft_clr;
        accept     = wr_a2 && !fifo_full;
`ifdef GCD_ACCEL_BINARY_EN
        result     = (a_q | b_q) << k_q;
`else
        result     = a_q | b_q;
`endif
        status = {19'd0, 5'(count_q), 3'd0, ovf_q, done_q, fifo_empty, fifo_full,
                  state_q != S_IDLE};
        case (saddress)
            ADDR_A1:   rmux = 32'(a1_q);
            ADDR_A2:   rmux = 32'(a2_q);
            ADDR_W:    rmux = 32'(w_q);
            ADDR_S:    rmux = status;
            ADDR_JOBS: rmux = jobs_q;
            ADDR_ID:   rmux = 32'h12345678;
            default:   rmux = 32'd0;
        endcase
        rdata_d = srd ? rmux : rdata_q;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        w_d      = w_q;
        jobs_d   = jobs_q;
        ovf_d    = ovf_q;
        done_d   = done_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        complete = 1'b0;
`ifdef GCD_ACCEL_BINARY_EN
        k_d      = k_q;
`endif
        if (wr_a1) a1_d = sdata_in[WIDTH-1:0];
        if (wr_a2) a2_d = sdata_in[WIDTH-1:0];
        if (accept) begin
            mem_d[wr_ptr_q] = {a1_q, sdata_in[WIDTH-1:0]};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            jobs_d          = jobs_q + 32'd1;
        end
        if (wr_a2 && fifo_full) ovf_d = 1'b1;
        if (wr_s && sdata_in[4]) ovf_d = 1'b0;
        if (rd_w) done_d = 1'b0;
        count_d = count_q + CW'(accept) - CW'(pop);

        case (state_q)
            S_IDLE: if (pop) begin
                {a_d, b_d} = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                state_d    = S_RUN;
`ifdef GCD_ACCEL_BINARY_EN
                k_d        = '0;
`endif
            end
            S_RUN: begin
                if (a_q == '0 || b_q == '0 || a_q == b_q) begin
                    if (!done_q) begin
                        w_d      = result;
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        // park the finished result in a until the host drains W
                        a_d     = result;
                        state_d = S_HOLD;
                    end
`ifdef GCD_ACCEL_BINARY_EN
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
`else
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
`endif
            end
            S_HOLD: if (!done_q) begin
                w_d      = a_q;
                complete = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (complete) done_d = 1'b1;

        if (soft_clr) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = S_IDLE;
            done_d   = 1'b0;
            w_d      = w_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            w_q      <= '0;
            jobs_q   <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef GCD_ACCEL_BINARY_EN
            k_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            w_q      <= w_d;
            jobs_q   <= jobs_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
`ifdef GCD_ACCEL_BINARY_EN
            k_q      <= k_d;
`endif
        end
    end

    assign sdata_out = rdata_q;
    assign gpio_out  = jobs_q;
    assign irq       = done_q;
endmodule

// File: tb/tb_gcd_accel.sv
// tb/tb_gcd_accel.sv - self-checking bench for gcd_accel with a Euclid reference model
module tb_gcd_accel;
    localparam logic [15:0] BASE = 16'h00F8;
    localparam logic [15:0] O_A1 = 16'h00, O_A2 = 16'h04, O_W = 16'h08;
    localparam logic [15:0] O_S = 16'h0C, O_JOBS = 16'h10, O_ID = 16'h14;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0, swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out, gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv, last_w;
    logic [31:0] expq[$];

    gcd_accel dut (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d);
        @(negedge clk);
        swr = 1'b1; saddress = BASE + off; sdata_in = d;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] off, output logic [31:0] d);
        @(negedge clk);
        srd = 1'b1; saddress = BASE + off;
        @(negedge clk);
        srd = 1'b0;
        d = sdata_out;
    endtask

    task automatic wait_irq(input int limit);
        int n = 0;
        while (!irq && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("irq_timeout", {31'd0, irq}, 32'd1);
    endtask

    task automatic push_job(input logic [31:0] x, input logic [31:0] y);
        wr(O_A1, x);
        wr(O_A2, y);
        expq.push_back(ref_gcd(x, y));
    endtask

    task automatic drain(input string tag);
        logic [31:0] e;
        wait_irq(3000);
        rd(O_W, rv);
        e = expq.pop_front();
        check(tag, rv, e);
        last_w = e;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        check("rst_sdata_out", sdata_out, 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(O_S, rv);  check("rst_status", rv, 32'h4);
        rd(O_W, rv);  check("rst_w", rv, 32'd0);
        rd(O_ID, rv); check("id", rv, 32'h12345678);
        rd(16'h0040, rv); check("unmapped", rv, 32'd0);

        // (12,8): A2 written at E0, pop E1, steps E2/E3, result at E4
        wr(O_A1, 32'd12);
        wr(O_A2, 32'd8);
        repeat (3) @(negedge clk);
`ifndef GCD_ACCEL_BINARY_EN
        check("e3_irq_low", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("e4_irq_high", {31'd0, irq}, 32'd1);
`endif
        wait_irq(100);
        rd(O_W, rv);   check("w_12_8", rv, 32'd4);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd(O_JOBS, rv); check("jobs_1", rv, 32'd1);
        check("gpio_1", gpio_out, 32'd1);

        // zero operands complete on the first RUN edge
        wr(O_A1, 32'd0);
        wr(O_A2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("zero_zero_done", {31'd0, irq}, 32'd1);
        rd(O_W, rv); check("w_0_0", rv, 32'd0);
        wr(O_A1, 32'd0);
        wr(O_A2, 32'd35);
        @(negedge clk);
        @(negedge clk);
        check("zero_35_done", {31'd0, irq}, 32'd1);
        rd(O_W, rv); check("w_0_35", rv, 32'd35);

        // overflow: six back-to-back pushes, one dropped
        wr(O_A1, 32'd48);
        @(negedge clk);
        swr = 1'b1; saddress = BASE + O_A2; sdata_in = 32'd18;
        for (int i = 0; i < 6; i++) @(negedge clk);
        swr = 1'b0;
        for (int i = 0; i < 5; i++) expq.push_back(ref_gcd(32'd48, 32'd18));
        check("ovf_jobs", gpio_out, 32'd8);
        rd(O_S, rv); check("ovf_full_bits", rv & 32'h12, 32'h12);
        for (int i = 0; i < 5; i++) drain("ovf_drain");
        check("ovf_queue_empty", 32'(expq.size()), 32'd0);
        wr(O_S, 32'h10);
        rd(O_S, rv); check("ovf_cleared", rv, 32'h4);

        // randomized rounds against the reference model
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++)
                push_job($urandom_range(0, 255), $urandom_range(0, 255));
            for (int j = 0; j < 3; j++) drain("rand_w");
        end

        // soft clear with the engine running and three jobs queued
        wr(O_A1, 32'd255);
        for (int i = 0; i < 4; i++) wr(O_A2, 32'd1);
        repeat (3) @(negedge clk);
        wr(O_S, 32'h8000_0000);
        rd(O_S, rv);  check("softclr_status", rv, 32'h4);
        check("softclr_irq", {31'd0, irq}, 32'd0);
        rd(O_W, rv);  check("softclr_w_kept", rv, last_w);

`ifdef GCD_ACCEL_BINARY_EN
        push_job(32'hFFFF_FFFF, 32'd1);
        drain("bin_max_1");
        push_job(32'd96, 32'd64);
        drain("bin_96_64");
`endif

        // asynchronous reset in the middle of a computation
        rd(O_ID, rv);
        wr(O_A1, 32'd255);
        wr(O_A2, 32'd1);
        repeat (5) @(negedge clk);
        #3 n_reset = 1'b0;
        #1;
        check("arst_sdata_out", sdata_out, 32'd0);
        check("arst_gpio_out", gpio_out, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        rd(O_S, rv); check("arst_status", rv, 32'h4);
        push_job(32'd9, 32'd6);
        drain("post_rst_9_6");
        check("post_rst_jobs", gpio_out, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
